// File: rtl/bitwise_result_serializer.sv
// Captures the seven bitwise_operators results on load and streams them out one word per
// beat over a valid/ready handshake, counting completed frames and flagging dropped loads.
module bitwise_result_serializer #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] u,
   input  logic [WIDTH-1:0] v,
   input  logic [WIDTH-1:0] w,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] z,
   input  logic [WIDTH-1:0] s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       out_idx,
   output logic             out_last,
   output logic             busy,
   output logic             load_drop,
   output logic [CNT_W-1:0] frame_cnt
);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [WIDTH-1:0] cap_q [7];
   logic             fire, final_beat, capture, drop_d;

   always_comb begin
      fire       = (state_q == StSend) && out_ready;
      final_beat = fire && (idx_q == 3'd6);
      // A load on the final transfer edge chains the next frame instead of being dropped.
      capture    = load && ((state_q == StIdle) || final_beat);
      drop_d     = load && (state_q == StSend) && !final_beat;

      state_d = state_q;
      idx_d   = idx_q;
      if (capture) begin
         state_d = StSend;
         idx_d   = 3'd0;
      end else if (final_beat) begin
         state_d = StIdle;
         idx_d   = 3'd0;
      end else if (fire) begin
         idx_d = idx_q + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         idx_q     <= 3'd0;
         load_drop <= 1'b0;
         frame_cnt <= '0;
         for (int i = 0; i < 7; i++) cap_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         load_drop <= drop_d;
         if (final_beat) frame_cnt <= frame_cnt + 1'b1;
         if (capture) begin
            cap_q[0] <= u;
            cap_q[1] <= v;
            cap_q[2] <= w;
            cap_q[3] <= x;
            cap_q[4] <= y;
            cap_q[5] <= z;
            cap_q[6] <= s;
         end
      end
   end

   always_comb begin
      out_valid = (state_q == StSend);
      busy      = (state_q == StSend);
      out_idx   = idx_q;
      out_last  = out_valid && (idx_q == 3'd6);
      out_data  = '0;
      if (out_valid) begin
         case (idx_q)
            3'd0:    out_data = cap_q[0];
            3'd1:    out_data = cap_q[1];
            3'd2:    out_data = cap_q[2];
            3'd3:    out_data = cap_q[3];
            3'd4:    out_data = cap_q[4];
            3'd5:    out_data = cap_q[5];
            3'd6:    out_data = cap_q[6];
            default: out_data = '0;
         endcase
      end
   end

endmodule
